// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm controller slice.
// State encoding is visible on the estado output, so the values are fixed.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOUNDING  = 2'd1,
        SILENCED  = 2'd2,
        TIMED_OUT = 2'd3
    } state_t;

    localparam int BLINK_HALF_DEF    = 4;
    localparam int SOUND_TIMEOUT_DEF = 32;
    localparam int CNT_W             = 4;
    localparam int TIMER_W           = 8;

endpackage

// File: rtl/blink_timer.sv
// Clearable down-counter giving a one-cycle tick every BLINK_HALF running cycles.
// A clear reloads the full half-period, so the first tick lands BLINK_HALF cycles later.
module blink_timer
    import alarm_pkg::*;
#(
    parameter int BLINK_HALF = BLINK_HALF_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic run_i,
    output logic tick_o
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(BLINK_HALF - 1);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = RELOAD;
        end else if (run_i) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = run_i && !clear_i && (cnt_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// Alarm FSM with blinking siren, sound timeout and saturating event counter.
// All outputs come straight from registers updated on the rising edge.
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int BLINK_HALF    = BLINK_HALF_DEF,
    parameter int SOUND_TIMEOUT = SOUND_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alarme,
    input  logic             enable,
    input  logic             ack,
    output logic             sirene,
    output logic             led_alarme,
    output logic [CNT_W-1:0] num_alarmes,
    output logic [1:0]       estado
);

    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(SOUND_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX  = '1;

    state_t             state_q;
    logic               sirene_q;
    logic               led_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [TIMER_W-1:0] tmo_q;
    logic [TIMER_W-1:0] tmo_d;
    logic               sounding;
    logic               timeout;
    logic               blink_tick;

    assign sounding = (state_q == SOUNDING);
    assign timeout  = sounding && (tmo_q == TMO_LAST);

    // Alarm events count in every armed state; the FSM priority only steers state.
    always_comb begin
        cnt_d = cnt_q;
        if (enable && alarme && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counts cycles in SOUNDING; a fresh alarm restarts it.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (!sounding || alarme) begin
            tmo_d = '0;
        end
    end

    blink_timer #(
        .BLINK_HALF (BLINK_HALF)
    ) u_blink (
        .clk     (clk),
        .reset   (reset),
        .clear_i (!sounding),
        .run_i   (sounding),
        .tick_o  (blink_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sirene_q <= 1'b0;
            led_q    <= 1'b0;
            cnt_q    <= '0;
            tmo_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
            if (!enable) begin
                state_q  <= IDLE;
                sirene_q <= 1'b0;
                led_q    <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (alarme) begin
                            state_q  <= SOUNDING;
                            sirene_q <= 1'b1;
                            led_q    <= 1'b1;
                        end
                    end
                    SOUNDING: begin
                        if (ack) begin
                            state_q  <= SILENCED;
                            sirene_q <= 1'b0;
                            led_q    <= 1'b1;
                        end else if (timeout) begin
                            state_q  <= TIMED_OUT;
                            sirene_q <= 1'b0;
                            led_q    <= 1'b1;
                        end else if (blink_tick) begin
                            sirene_q <= !sirene_q;
                        end
                    end
                    SILENCED: begin
                        if (!ack) begin
                            state_q <= IDLE;
                            led_q   <= 1'b0;
                        end
                    end
                    TIMED_OUT: begin
                        if (ack) begin
                            state_q <= IDLE;
                            led_q   <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= IDLE;
                        sirene_q <= 1'b0;
                        led_q    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sirene      = sirene_q;
    assign led_alarme  = led_q;
    assign num_alarmes = cnt_q;
    assign estado      = state_q;

endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have parameter BLINK_HALF, default 4, giving the number of cycles per siren half-period (legal range 1..255).
REQ-003 The block SHALL have parameter SOUND_TIMEOUT, default 32, giving the maximum number of cycles spent in SOUNDING (legal range 2..255).
REQ-004 clk: input, 1 bit, rising-edge system clock.
REQ-005 reset: input, 1 bit, synchronous active-high reset.
REQ-006 alarme: input, 1 bit, one-cycle pulse from the lamp sequence detector.
REQ-007 enable: input, 1 bit, system armed when 1.
REQ-008 ack: input, 1 bit, operator acknowledge button (level).
REQ-009 sirene: output, 1 bit, blinking siren drive.
REQ-010 led_alarme: output, 1 bit, steady indicator that an alarm is pending or has been acknowledged.
REQ-011 num_alarmes: output, 4 bits, saturating count of accepted alarm events.
REQ-012 estado: output, 2 bits, current state encoding.

Function
REQ-013 States SHALL be encoded as follows: IDLE=0, SOUNDING=1, SILENCED=2, TIMED_OUT=3.
REQ-014 All outputs SHALL be registered; a condition sampled at edge n SHALL be visible on the outputs immediately after edge n.
REQ-015 Transition priority SHALL be, highest first: reset, then enable=0, then ack, then timeout, then alarme.
REQ-016 With enable=0 in any state, the next state SHALL be IDLE, sirene SHALL be 0, led_alarme SHALL be 0, alarme SHALL be ignored and not counted, and num_alarmes SHALL be held.
REQ-017 From IDLE, alarme=1 with enable=1 SHALL move to SOUNDING, set sirene=1, set led_alarme=1, clear the timeout and blink counters, and increment num_alarmes.
REQ-018 In SOUNDING, sirene SHALL toggle every BLINK_HALF cycles, with the first toggle BLINK_HALF cycles after entry.
REQ-019 In SOUNDING, ack=1 SHALL move to SILENCED with sirene=0 and led_alarme=1.
REQ-020 In SOUNDING, once SOUND_TIMEOUT cycles have elapsed since entry or the last restart, the block SHALL move to TIMED_OUT with sirene=0 and led_alarme=1.
REQ-021 If ack and the timeout occur in the same cycle, ack SHALL win and the next state SHALL be SILENCED.
REQ-022 alarme=1 while in SOUNDING SHALL increment num_alarmes and restart the timeout counter, while the blink phase continues uninterrupted.
REQ-023 In SILENCED, ack=0 SHALL move to IDLE with led_alarme=0; alarme arriving while in SILENCED SHALL increment num_alarmes only.
REQ-024 In TIMED_OUT, ack=1 SHALL move to IDLE with led_alarme=0; alarme arriving while in TIMED_OUT SHALL increment num_alarmes only.
REQ-025 num_alarmes SHALL saturate at 15 and never wrap to 0; it SHALL be cleared only by reset.
REQ-026 sirene SHALL be 0 in every state other than SOUNDING.

Reset
REQ-027 While reset=1 at a rising edge, the block SHALL set state=IDLE, sirene=0, led_alarme=0, num_alarmes=0, and both internal counters to 0.
REQ-028 A reset asserted mid-alarm SHALL override every other input in that cycle, including ack and alarme.

Structure
REQ-029 Package alarm_pkg SHALL hold the state enum, the BLINK_HALF and SOUND_TIMEOUT defaults, and the count width constant (4).
REQ-030 Sub-module blink_timer SHALL implement the clearable down-counter that produces a one-cycle tick every BLINK_HALF cycles.
REQ-031 The FSM, the timeout counter and the event counter SHALL reside in alarm_controller.

Verification
REQ-032 Scenario 1, with defaults: reset, enable=1, alarme pulse at cycle 10 -> estado=1, sirene=1, num_alarmes=1 after edge 10; sirene=0 after edge 14 and 1 again after edge 18.
REQ-033 Scenario 2, timeout: no ack after the pulse at cycle 10 -> estado=3 and sirene=0 after edge 42; ack at cycle 50 -> estado=0 and led_alarme=0.
REQ-034 Scenario 3, ack/timeout collision: ack raised exactly in the timeout cycle -> estado=2, not 3; ack released -> estado=0 on the next edge.
REQ-035 Scenario 4, saturation: 20 alarme pulses spread across states with enable=1 -> num_alarmes=15 and stays at 15.
REQ-036 Scenario 5, disarm: enable=0 while SOUNDING -> estado=0 and sirene=0 next edge; an alarme pulse while enable=0 -> num_alarmes unchanged.
REQ-037 Scenario 6, reset priority: reset=1 together with alarme=1 in SOUNDING -> all outputs 0 and estado=0 next edge.
